// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency results
// queue in a small FIFO and drain on idle port cycles, with squash and starvation stall.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_v,
    input  logic        i_wb_reg_wen,
    input  logic [4:0]  i_wb_dr,
    input  logic [63:0] i_wb_data,
    input  logic        i_ll_v,
    output logic        o_ll_ready,
    input  logic [4:0]  i_ll_dr,
    input  logic [63:0] i_ll_res,
    input  logic        i_ll_w,
    output logic        o_de_reg_wen,
    output logic [4:0]  o_de_dr,
    output logic [63:0] o_de_data,
    output logic [31:0] o_pending,
    output logic        o_stall_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       r_dr   [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WW-1:0]    r_wait;
    logic             r_stall;
    logic [31:0]      r_pending;

    logic             w_wb_use;
    logic             w_occ;
    logic             w_head_live;
    logic             w_pop;
    logic             w_ready;
    logic             w_push;
    logic             w_push_live;
    logic [63:0]      w_push_data;
    logic [DEPTH-1:0] w_live_nxt;
    logic [4:0]       w_dr_nxt [DEPTH];
    logic [31:0]      w_pend_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WW-1:0]    w_wait_nxt;

    assign w_wb_use    = i_wb_v & i_wb_reg_wen & (i_wb_dr != 5'd0);
    assign w_occ       = (r_count != {CW{1'b0}});
    assign w_head_live = w_occ & r_live[r_head];
    // A dead head retires silently every cycle; a live one only when writeback is idle.
    assign w_pop       = w_occ & (~r_live[r_head] | ~w_wb_use);
    assign w_ready     = (r_count < CW'(DEPTH));
    assign w_push      = i_ll_v & w_ready;
    assign w_push_data = i_ll_w ? {32'h0000_0000, i_ll_res[31:0]} : i_ll_res;
    // Results are older than writeback, so a matching writeback makes them stale.
    assign w_push_live = (i_ll_dr != 5'd0) & ~(w_wb_use & (i_ll_dr == i_wb_dr));

    // Post-edge liveness and destinations, used to register the pending mask.
    always_comb begin
        w_pend_nxt = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_tail == PW'(i))) begin
                w_live_nxt[i] = w_push_live;
                w_dr_nxt[i]   = i_ll_dr;
            end else begin
                w_live_nxt[i] = r_live[i]
                              & ~(w_wb_use & (r_dr[i] == i_wb_dr))
                              & ~(w_pop & (r_head == PW'(i)));
                w_dr_nxt[i]   = r_dr[i];
            end
            w_pend_nxt = w_pend_nxt | ({31'h0000_0000, w_live_nxt[i]} << w_dr_nxt[i]);
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Occupancy and starvation counter next-state.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_pop) begin
            w_wait_nxt = {WW{1'b0}};
        end else if (w_head_live && (r_wait != WW'(MAX_WAIT))) begin
            w_wait_nxt = r_wait + WW'(1);
        end else begin
            w_wait_nxt = r_wait;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_live    <= {DEPTH{1'b0}};
            r_head    <= {PW{1'b0}};
            r_tail    <= {PW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_wait    <= {WW{1'b0}};
            r_stall   <= 1'b0;
            r_pending <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                r_dr[i] <= 5'd0;
            end
        end else begin
            r_live    <= w_live_nxt;
            r_count   <= w_count_nxt;
            r_wait    <= w_wait_nxt;
            r_stall   <= (w_wait_nxt >= WW'(MAX_WAIT));
            r_pending <= w_pend_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_dr[i] <= w_dr_nxt[i];
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
        end
    end

    // Result payload storage; no reset needed, qualified by liveness.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data[r_tail] <= w_push_data;
        end
    end

    // Write-port select: writeback first, then a live buffer head.
    always_comb begin
        o_de_reg_wen = 1'b0;
        o_de_dr      = 5'd0;
        o_de_data    = 64'h0;
        if (!i_reset_n) begin
            o_de_reg_wen = 1'b0;
        end else if (w_wb_use) begin
            o_de_reg_wen = 1'b1;
            o_de_dr      = i_wb_dr;
            o_de_data    = i_wb_data;
        end else if (w_head_live) begin
            o_de_reg_wen = 1'b1;
            o_de_dr      = r_dr[r_head];
            o_de_data    = r_data[r_head];
        end else begin
            o_de_reg_wen = 1'b0;
        end
    end

    assign o_ll_ready  = i_reset_n & w_ready;
    assign o_stall_req = i_reset_n & r_stall;
    assign o_pending   = i_reset_n ? r_pending : 32'h0000_0000;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n, wb_v, wb_wen, ll_v, ll_w;
    logic [4:0]  wb_dr, ll_dr;
    logic [63:0] wb_data, ll_res;
    logic        o_ll_ready, o_de_reg_wen, o_stall_req;
    logic [4:0]  o_de_dr;
    logic [63:0] o_de_data;
    logic [31:0] o_pending;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  dr;
        logic [63:0] data;
        bit          live;
    } ent_t;

    ent_t q[$];
    int   mwait = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_v(wb_v), .i_wb_reg_wen(wb_wen), .i_wb_dr(wb_dr), .i_wb_data(wb_data),
        .i_ll_v(ll_v), .o_ll_ready(o_ll_ready), .i_ll_dr(ll_dr), .i_ll_res(ll_res), .i_ll_w(ll_w),
        .o_de_reg_wen(o_de_reg_wen), .o_de_dr(o_de_dr), .o_de_data(o_de_data),
        .o_pending(o_pending), .o_stall_req(o_stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the effect of one clock edge to the model, using the inputs held this cycle.
    task automatic model_update();
        bit   use_wb, can_push, popped, waited;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            mwait = 0;
        end else begin
            use_wb   = wb_v && wb_wen && (wb_dr != 5'd0);
            can_push = (q.size() < DEPTH);
            popped   = (q.size() > 0) && (!q[0].live || !use_wb);
            waited   = (q.size() > 0) && q[0].live && !popped;
            foreach (q[i]) if (use_wb && q[i].dr == wb_dr) q[i].live = 1'b0;
            if (popped) void'(q.pop_front());
            if (ll_v && can_push) begin
                e.dr   = ll_dr;
                e.data = ll_w ? {32'h0, ll_res[31:0]} : ll_res;
                e.live = (ll_dr != 5'd0) && !(use_wb && ll_dr == wb_dr);
                q.push_back(e);
            end
            if (popped) mwait = 0;
            else if (waited && mwait < MAX_WAIT) mwait++;
        end
    endtask

    task automatic model_check();
        logic        e_ready, e_stall, e_wen, use_wb;
        logic [31:0] e_pend;
        logic [4:0]  e_dr;
        logic [63:0] e_data;
        e_ready = 1'b0; e_stall = 1'b0; e_wen = 1'b0; e_pend = 32'h0;
        e_dr = 5'd0; e_data = 64'h0;
        if (rst_n) begin
            use_wb  = wb_v && wb_wen && (wb_dr != 5'd0);
            e_ready = (q.size() < DEPTH);
            e_stall = (mwait >= MAX_WAIT);
            foreach (q[i]) if (q[i].live) e_pend[q[i].dr] = 1'b1;
            if (use_wb) begin
                e_wen = 1'b1; e_dr = wb_dr; e_data = wb_data;
            end else if (q.size() > 0 && q[0].live) begin
                e_wen = 1'b1; e_dr = q[0].dr; e_data = q[0].data;
            end
        end
        chk("ll_ready", 64'(o_ll_ready), 64'(e_ready));
        chk("stall_req", 64'(o_stall_req), 64'(e_stall));
        chk("pending", 64'(o_pending), 64'(e_pend));
        chk("reg_wen", 64'(o_de_reg_wen), 64'(e_wen));
        if (e_wen) begin
            chk("de_dr", 64'(o_de_dr), 64'(e_dr));
            chk("de_data", o_de_data, e_data);
        end
    endtask

    task automatic step_begin();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step_end();
        #1;
        model_check();
    endtask

    task automatic cyc(input logic r, input logic wv, input logic [4:0] wd,
                       input logic lv, input logic [4:0] ld, input logic [63:0] lr,
                       input logic lw);
        step_begin();
        rst_n = r; wb_v = wv; wb_wen = wv; wb_dr = wd; wb_data = {$urandom, $urandom};
        ll_v = lv; ll_dr = ld; ll_res = lr; ll_w = lw;
        step_end();
    endtask

    initial begin
        int pwb, pll;
        rst_n = 1'b0; wb_v = 1'b0; wb_wen = 1'b0; wb_dr = 5'd0; wb_data = 64'h0;
        ll_v = 1'b0; ll_dr = 5'd0; ll_res = 64'h0; ll_w = 1'b0;
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("reset_wen", 64'(o_de_reg_wen), 64'd0);
        chk("reset_ready", 64'(o_ll_ready), 64'd0);

        // Idle port: 32-bit result zero-extended, written the cycle after push.
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 64'hFFFF_FFFF_1234_5678, 1'b1);
        chk("idle_ready", 64'(o_ll_ready), 64'd1);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("idle_wen", 64'(o_de_reg_wen), 64'd1);
        chk("idle_dr", 64'(o_de_dr), 64'd5);
        chk("idle_data", o_de_data, 64'h0000_0000_1234_5678);
        chk("idle_pend_set", 64'(o_pending), 64'h20);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("idle_pend_clr", 64'(o_pending), 64'h0);
        chk("idle_no_wen", 64'(o_de_reg_wen), 64'd0);

        // Priority: writeback owns the port while active.
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 64'hAAAA_0000_0000_0007, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 1'b0);
            chk("prio_wb_dr", 64'(o_de_dr), 64'd3);
        end
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("prio_ll_dr", 64'(o_de_dr), 64'd7);
        chk("prio_ll_data", o_de_data, 64'hAAAA_0000_0000_0007);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);

        // Squash: writeback to the same register kills the buffered result.
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 64'h9999, 1'b0);
        cyc(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("squash_pend_before", 64'(o_pending), 64'h200);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("squash_pend_after", 64'(o_pending), 64'h0);
        chk("squash_no_write", 64'(o_de_reg_wen), 64'd0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);

        // Full buffer and backpressure.
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd10, 64'h10, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd11, 64'h11, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd12, 64'h12, 1'b0);
        chk("full_ready", 64'(o_ll_ready), 64'd0);
        chk("full_pend", 64'(o_pending), 64'h0C00);
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd12, 64'h12, 1'b0);
        chk("full_hold", 64'(o_ll_ready), 64'd0);
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd12, 64'h12, 1'b0);
        chk("full_free_cycle", 64'(o_ll_ready), 64'd0);
        chk("full_drain_dr", 64'(o_de_dr), 64'd10);
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd12, 64'h12, 1'b0);
        chk("full_ready_again", 64'(o_ll_ready), 64'd1);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("full_third_dr", 64'(o_de_dr), 64'd12);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);

        // Starvation stall after MAX_WAIT waiting cycles.
        cyc(1'b1, 1'b0, 5'd0, 1'b1, 5'd13, 64'h13, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            cyc(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 1'b0);
            chk("starve_low", 64'(o_stall_req), 64'd0);
        end
        cyc(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("starve_high", 64'(o_stall_req), 64'd1);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("starve_write_dr", 64'(o_de_dr), 64'd13);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("starve_release", 64'(o_stall_req), 64'd0);

        // Reset in the middle of a stalled, full buffer.
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd14, 64'h14, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 1'b1, 5'd15, 64'h15, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++) cyc(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("mid_stall", 64'(o_stall_req), 64'd1);
        chk("mid_pend", 64'(o_pending), 64'h0000_C000);
        cyc(1'b0, 1'b1, 5'd3, 1'b1, 5'd16, 64'h16, 1'b0);
        chk("rst_wen", 64'(o_de_reg_wen), 64'd0);
        chk("rst_stall", 64'(o_stall_req), 64'd0);
        chk("rst_pend", 64'(o_pending), 64'h0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("post_rst_wen", 64'(o_de_reg_wen), 64'd0);
        chk("post_rst_ready", 64'(o_ll_ready), 64'd1);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
        chk("post_rst_idle", 64'(o_de_reg_wen), 64'd0);

        // Randomized traffic with varying writeback / long-latency pressure.
        pwb = 50; pll = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                pwb = $urandom_range(0, 100);
                pll = $urandom_range(10, 100);
            end
            step_begin();
            rst_n   = ($urandom_range(0, 199) != 0);
            wb_v    = ($urandom_range(0, 99) < pwb);
            wb_wen  = ($urandom_range(0, 9) != 0);
            wb_dr   = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            ll_v    = ($urandom_range(0, 99) < pll);
            ll_dr   = 5'($urandom_range(0, 7));
            ll_res  = {$urandom, $urandom};
            ll_w    = 1'($urandom_range(0, 1));
            step_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
